imm_alu_sequencer: RTL and testbench

- Hardwired control unit that replaces hand-driven testbench stimulus for the datapath.
- Walks the fetch steps T0–T2, then executes the immediate-ALU class (addi/andi/ori) in T3–T5, one control step per clock.
- Generalises the single hardcoded addi sequence: opcode-to-ALU-operation mapping is parametrised, memory reads use a ready handshake with timeout, and halt and illegal-opcode handling are added.
- Sits beside the datapath; its outputs drive the datapath strobe inputs directly.

---
 rtl/imm_alu_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_imm_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_alu_sequencer.sv
// rtl/imm_alu_sequencer.sv - hardwired fetch/execute control unit for the immediate-ALU instruction class
module imm_alu_sequencer #(
    parameter int                OP_W        = 5,
    parameter logic [OP_W-1:0]   OP_ADDI     = 5'b01100,
    parameter logic [OP_W-1:0]   OP_ANDI     = 5'b01101,
    parameter logic [OP_W-1:0]   OP_ORI      = 5'b01110,
    parameter logic [OP_W-1:0]   OP_HALT     = 5'b11011,
    parameter logic [OP_W-1:0]   ALU_ADD     = 5'b00011,
    parameter logic [OP_W-1:0]   ALU_AND     = 5'b00101,
    parameter logic [OP_W-1:0]   ALU_OR      = 5'b00110,
    parameter int                MEM_TIMEOUT = 8,
    parameter int                COUNT_W     = 16
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Run,
    input  logic               Mem_ready,
    input  logic [OP_W-1:0]    IR_opcode,
    output logic               PCout,
    output logic               MARin,
    output logic               IncPC,
    output logic               PCin,
    output logic               Read,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Yin,
    output logic               Zin,
    output logic               Zlowout,
    output logic               Cout,
    output logic               GRA,
    output logic               GRB,
    output logic               Rin,
    output logic               Rout,
    output logic [OP_W-1:0]    operation,
    output logic               Done,
    output logic               Halted,
    output logic [1:0]         Fault,
    output logic [COUNT_W-1:0] Instr_count,
    output logic [3:0]         State_out
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_HALT  = 4'd7,
        S_FAULT = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic [OP_W-1:0]     r_opcode;
    logic [1:0]          r_fault;
    logic [COUNT_W-1:0]  r_count;
    logic                w_alu_op;
    logic                w_timeout;

    assign w_alu_op   = (IR_opcode == OP_ADDI) || (IR_opcode == OP_ANDI) || (IR_opcode == OP_ORI);
    assign w_wait_inc = r_wait + 1'b1;
    // Ready in the same cycle as the last allowed wait still proceeds to T2.
    assign w_timeout  = (MEM_TIMEOUT != 0) && !Mem_ready && (w_wait_inc == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state  <= S_IDLE;
            r_wait   <= '0;
            r_opcode <= '0;
            r_fault  <= 2'b00;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T1 && !Mem_ready && !w_timeout) begin
                if (r_wait != '1) begin
                    r_wait <= w_wait_inc;
                end
            end else begin
                r_wait <= '0;
            end
            if (r_state == S_T3) begin
                r_opcode <= IR_opcode;
            end
            if (r_state == S_T1 && w_timeout) begin
                r_fault[0] <= 1'b1;
            end
            if (r_state == S_T3 && !w_alu_op && IR_opcode != OP_HALT) begin
                r_fault[1] <= 1'b1;
            end
            if (r_state == S_T5) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Run) w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1: begin
                if (Mem_ready)      w_next = S_T2;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_T2:    w_next = S_T3;
            S_T3: begin
                if (w_alu_op)                  w_next = S_T4;
                else if (IR_opcode == OP_HALT) w_next = S_HALT;
                else                           w_next = S_FAULT;
            end
            S_T4:    w_next = S_T5;
            S_T5:    w_next = Run ? S_T0 : S_IDLE;
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        Cout      = 1'b0;
        GRA       = 1'b0;
        GRB       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        operation = '0;
        Done      = 1'b0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = (r_wait == '0);
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                GRB  = w_alu_op;
                Rout = w_alu_op;
                Yin  = w_alu_op;
            end
            S_T4: begin
                Cout = 1'b1;
                Zin  = 1'b1;
                if (r_opcode == OP_ADDI)      operation = ALU_ADD;
                else if (r_opcode == OP_ANDI) operation = ALU_AND;
                else if (r_opcode == OP_ORI)  operation = ALU_OR;
            end
            S_T5: begin
                Zlowout = 1'b1;
                GRA     = 1'b1;
                Rin     = 1'b1;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign Halted      = (r_state == S_HALT);
    assign Fault       = r_fault;
    assign Instr_count = r_count;
    assign State_out   = r_state;
endmodule

// File: tb/tb_imm_alu_sequencer.sv
// tb/tb_imm_alu_sequencer.sv - scoreboard bench for imm_alu_sequencer with directed instruction sequences
module tb_imm_alu_sequencer;
    logic        clk = 1'b0;
    logic        Clear = 1'b1;
    logic        Run = 1'b0;
    logic        Mem_ready = 1'b0;
    logic [4:0]  IR_opcode = 5'b0;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Cout, GRA, GRB, Rin, Rout;
    logic [4:0]  operation;
    logic        Done, Halted;
    logic [1:0]  Fault;
    logic [15:0] Instr_count;
    logic [3:0]  State_out;

    imm_alu_sequencer dut (
        .Clock(clk), .Clear(Clear), .Run(Run), .Mem_ready(Mem_ready), .IR_opcode(IR_opcode),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
        .GRA(GRA), .GRB(GRB), .Rin(Rin), .Rout(Rout), .operation(operation), .Done(Done),
        .Halted(Halted), .Fault(Fault), .Instr_count(Instr_count), .State_out(State_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] str;
        logic [4:0]  oper;
        logic        dn;
        logic        hl;
        logic [1:0]  flt;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_cyc   = 0;
    logic [4:0] op_v = 5'b0;

    localparam logic [4:0] ADDI = 5'b01100, ANDI = 5'b01101, ORI = 5'b01110, HALT = 5'b11011;

    // Strobe order: PCout MARin IncPC PCin Read MDRin MDRout IRin Yin Zin Zlowout Cout GRA GRB Rin Rout
    function automatic logic [15:0] str_of(input logic [3:0] st, input bit first, input bit alu);
        case (st)
            4'd1:    return 16'hE040;
            4'd2:    return first ? 16'h1C20 : 16'h0C20;
            4'd3:    return 16'h0300;
            4'd4:    return alu ? 16'h0085 : 16'h0000;
            4'd5:    return 16'h0050;
            4'd6:    return 16'h002A;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push_exp(input logic [3:0] st, input logic [4:0] oper, input logic [1:0] flt,
                            input logic hl, input logic [15:0] cnt, input bit first, input bit alu);
        exp_t e;
        e.st   = st;
        e.str  = str_of(st, first, alu);
        e.oper = oper;
        e.dn   = (st == 4'd6);
        e.hl   = hl;
        e.flt  = flt;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic clr, input logic run, input logic rdy, input logic [3:0] st,
                        input logic [4:0] oper, input logic [1:0] flt, input logic hl,
                        input logic [15:0] cnt, input bit first, input bit alu);
        @(negedge clk);
        #1;
        Clear     = clr;
        Run       = run;
        Mem_ready = rdy;
        IR_opcode = op_v;
        push_exp(st, oper, flt, hl, cnt, first, alu);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 2'b00, 1'b0, 16'd0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        n_cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.st   = State_out;
            a.str  = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                      Yin, Zin, Zlowout, Cout, GRA, GRB, Rin, Rout};
            a.oper = operation;
            a.dn   = Done;
            a.hl   = Halted;
            a.flt  = Fault;
            a.cnt  = Instr_count;
            n_total++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL cyc%0d got st=%0d str=%h op=%b done=%b halt=%b fault=%b cnt=%0d exp st=%0d str=%h op=%b done=%b halt=%b fault=%b cnt=%0d",
                         n_cyc, a.st, a.str, a.oper, a.dn, a.hl, a.flt, a.cnt,
                         e.st, e.str, e.oper, e.dn, e.hl, e.flt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // addi from reset
        op_v = ADDI;
        do_reset();
        step(0, 0, 0, 4'd0, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 1);
        step(0, 1, 1, 4'd5, 5'b00011, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd6, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd1, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd1, 0, 0);

        // andi then ori back-to-back
        do_reset();
        op_v = ANDI;
        step(0, 1, 1, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 1);
        step(0, 1, 1, 4'd5, 5'b00101, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd6, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        op_v = ORI;
        step(0, 1, 1, 4'd1, 5'd0, 2'b00, 0, 16'd1, 0, 0);
        step(0, 1, 1, 4'd2, 5'd0, 2'b00, 0, 16'd1, 1, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd1, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd1, 0, 1);
        step(0, 1, 1, 4'd5, 5'b00110, 2'b00, 0, 16'd1, 0, 0);
        step(0, 1, 1, 4'd6, 5'd0, 2'b00, 0, 16'd1, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd2, 0, 0);

        // three memory wait cycles
        do_reset();
        op_v = ADDI;
        step(0, 1, 0, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 0, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'd2, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 1);
        step(0, 1, 1, 4'd5, 5'b00011, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd6, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd1, 0, 0);

        // ready arriving on the last allowed wait cycle wins over timeout
        do_reset();
        step(0, 1, 0, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 0, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 4'd2, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 1);
        step(0, 1, 1, 4'd5, 5'b00011, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd6, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd1, 0, 0);

        // memory timeout after 8 wait cycles
        do_reset();
        step(0, 1, 0, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 0, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 4'd2, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 0, 4'd8, 5'd0, 2'b01, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd8, 5'd0, 2'b01, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd8, 5'd0, 2'b01, 0, 16'd0, 0, 0);

        // illegal opcode
        do_reset();
        op_v = 5'b00000;
        step(0, 1, 1, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd8, 5'd0, 2'b10, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd8, 5'd0, 2'b10, 0, 16'd0, 0, 0);

        // halt
        do_reset();
        op_v = HALT;
        step(0, 1, 1, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd7, 5'd0, 2'b00, 1, 16'd0, 0, 0);
        step(0, 1, 1, 4'd7, 5'd0, 2'b00, 1, 16'd0, 0, 0);
        step(0, 1, 1, 4'd7, 5'd0, 2'b00, 1, 16'd0, 0, 0);

        // Run dropped during T2
        do_reset();
        op_v = ORI;
        step(0, 1, 1, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        step(0, 0, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 1);
        step(0, 0, 1, 4'd5, 5'b00110, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd6, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd1, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd1, 0, 0);

        // Clear during T4 takes effect without a clock edge
        do_reset();
        op_v = ADDI;
        step(0, 1, 1, 4'd1, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd2, 5'd0, 2'b00, 0, 16'd0, 1, 0);
        step(0, 1, 1, 4'd3, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 1, 1, 4'd4, 5'd0, 2'b00, 0, 16'd0, 0, 1);
        step(0, 1, 1, 4'd5, 5'b00011, 2'b00, 0, 16'd0, 0, 0);
        @(negedge clk);
        #1;
        Clear = 1'b1;
        #1;
        n_total++;
        if (State_out === 4'd0 && operation === 5'd0 && Cout === 1'b0 && Zin === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL async_clear got st=%0d op=%b cout=%b zin=%b exp st=0 op=00000 cout=0 zin=0",
                     State_out, operation, Cout, Zin);
        end
        push_exp(4'd0, 5'd0, 2'b00, 0, 16'd0, 0, 0);
        step(0, 0, 1, 4'd0, 5'd0, 2'b00, 0, 16'd0, 0, 0);

        repeat (3) @(posedge clk);
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
